// File: rtl/id_seg_if.sv
// rtl/id_seg_if.sv - ID/EX pipeline register bundle produced by id_seg
//
// Purpose: carries the registered decode results from the ID stage to EX.
// Signals:
//   id_valid      instruction present (0 = bubble, all controls 0)
//   id_pc         PC of the decoded instruction
//   id_op/funct   opcode ir[31:26] / function ir[5:0]
//   id_rs/rt      source register fields
//   id_rd         destination register (0 when nothing is written)
//   id_imm        formed immediate (sext/zext/lui/pc+4)
//   id_rs_val/rt_val  register file read values
//   id_reg_write/mem_read/mem_write  control bits
// Modports: master (ID stage, drives), slave (EX stage, consumes).
interface id_seg_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [5:0]  id_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_imm;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;

  modport master (
    output id_valid, id_pc, id_op, id_funct, id_rs, id_rt, id_rd, id_imm,
           id_rs_val, id_rt_val, id_reg_write, id_mem_read, id_mem_write
  );

  modport slave (
    input id_valid, id_pc, id_op, id_funct, id_rs, id_rt, id_rd, id_imm,
          id_rs_val, id_rt_val, id_reg_write, id_mem_read, id_mem_write
  );
endinterface

// File: rtl/id_seg.sv
// rtl/id_seg.sv - MIPS-style instruction decode stage with IF/ID, regfile, hazards and branch resolve
//
// Purpose: holds the IF/ID register and the 32x32 register file, decodes the
// instruction, detects load-use / branch / writeback hazards, resolves
// branches and jumps in ID and registers the results into ID/EX.
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   ir_in, pc_in           fetched instruction and its PC
//   stall                  hold fetch PC and IF/ID (combinational)
//   cond, cond_npc         redirect fetch and its target (combinational)
//   wb_we, wb_rd, wb_data  register file write port
//   ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd  hazard inputs
//   idex                   ID/EX outputs (id_seg_if.master)
// Configuration: define REGFILE_BYPASS_EN to forward wb_data to same-cycle
// reads; otherwise a read matching the writeback register stalls one cycle.
module id_seg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc_in,
  output logic        stall,
  output logic        cond,
  output logic [31:0] cond_npc,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  id_seg_if.master    idex
);

  localparam logic [31:0] BUBBLE  = 32'hFFFF_FFFF;
  localparam logic [5:0]  OP_R    = 6'b000000;
  localparam logic [5:0]  OP_J    = 6'b000010;
  localparam logic [5:0]  OP_JAL  = 6'b000011;
  localparam logic [5:0]  OP_BEQ  = 6'b000100;
  localparam logic [5:0]  OP_BNE  = 6'b000101;
  localparam logic [5:0]  OP_ADDI = 6'b001000;
  localparam logic [5:0]  OP_ANDI = 6'b001100;
  localparam logic [5:0]  OP_ORI  = 6'b001101;
  localparam logic [5:0]  OP_LUI  = 6'b001111;
  localparam logic [5:0]  OP_LW   = 6'b100011;
  localparam logic [5:0]  OP_SW   = 6'b101011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } idex_t;

  logic [31:0] if_ir, if_pc;
  logic [31:0] rf [32];
  idex_t       idex_d, idex_q;

  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic [31:0] sext_imm, pc4;
  logic        bubble;
  assign op       = if_ir[31:26];
  assign rs       = if_ir[25:21];
  assign rt       = if_ir[20:16];
  assign sext_imm = {{16{if_ir[15]}}, if_ir[15:0]};
  assign pc4      = if_pc + 32'd4;
  assign bubble   = (if_ir == BUBBLE);

  // IF/ID: stall wins over redirect, redirect squashes the fetched slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ir <= BUBBLE;
      if_pc <= '0;
    end else if (!stall) begin
      if_ir <= cond ? BUBBLE : ir_in;
      if_pc <= pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Register reads; r0 is never written so it always reads 0.
  logic [31:0] rs_val, rt_val;
  logic        wb_hz;
  logic        uses_rs, uses_rt;
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs) rs_val = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rt) rt_val = wb_data;
  end
  assign wb_hz = 1'b0;
`else
  assign rs_val = rf[rs];
  assign rt_val = rf[rt];
  // Old value would be read; wait one cycle for the write to land.
  assign wb_hz = wb_we && wb_rd != 5'd0 &&
                 ((uses_rs && wb_rd == rs) || (uses_rt && wb_rd == rt));
`endif

  logic [4:0]  d_rd;
  logic [31:0] d_imm;
  logic        d_rw, d_mr, d_mw, is_br, is_jmp;
  always_comb begin
    d_rd    = '0;
    d_imm   = '0;
    d_rw    = 1'b0;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_br   = 1'b0;
    is_jmp  = 1'b0;
    case (op)
      OP_R:    begin d_rd = if_ir[15:11]; d_rw = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_ADDI: begin d_rd = rt; d_rw = 1'b1; d_imm = sext_imm; uses_rs = 1'b1; end
      OP_ANDI,
      OP_ORI:  begin d_rd = rt; d_rw = 1'b1; d_imm = {16'h0, if_ir[15:0]}; uses_rs = 1'b1; end
      OP_LUI:  begin d_rd = rt; d_rw = 1'b1; d_imm = {if_ir[15:0], 16'h0}; end
      OP_LW:   begin d_rd = rt; d_rw = 1'b1; d_mr = 1'b1; d_imm = sext_imm; uses_rs = 1'b1; end
      OP_SW:   begin d_mw = 1'b1; d_imm = sext_imm; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BEQ,
      OP_BNE:  begin d_imm = sext_imm; uses_rs = 1'b1; uses_rt = 1'b1; is_br = 1'b1; end
      OP_J:    is_jmp = 1'b1;
      OP_JAL:  begin is_jmp = 1'b1; d_rd = 5'd31; d_rw = 1'b1; d_imm = pc4; end
      default: ;
    endcase
  end

  // Branches compare in ID, so they also wait on any in-flight producer.
  logic load_use, br_hz, taken;
  assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                    ((uses_rs && ex_rd == rs) || (uses_rt && ex_rd == rt));
  assign br_hz    = is_br &&
                    ((ex_reg_write && ex_rd != 5'd0 && (ex_rd == rs || ex_rd == rt)) ||
                     (mem_mem_read && mem_rd != 5'd0 && (mem_rd == rs || mem_rd == rt)));
  assign taken    = is_jmp || (op == OP_BEQ && rs_val == rt_val) ||
                    (op == OP_BNE && rs_val != rt_val);

  assign stall    = !bubble && (load_use || br_hz || wb_hz);
  assign cond     = !bubble && !stall && taken;
  assign cond_npc = !cond  ? 32'h0 :
                    is_jmp ? {pc4[31:28], if_ir[25:0], 2'b00} :
                             pc4 + {sext_imm[29:0], 2'b00};

  always_comb begin
    idex_d = '0;
    if (!bubble && !stall) begin
      idex_d.valid     = 1'b1;
      idex_d.pc        = if_pc;
      idex_d.op        = op;
      idex_d.funct     = if_ir[5:0];
      idex_d.rs        = rs;
      idex_d.rt        = rt;
      idex_d.rd        = d_rd;
      idex_d.imm       = d_imm;
      idex_d.rs_val    = rs_val;
      idex_d.rt_val    = rt_val;
      idex_d.reg_write = d_rw;
      idex_d.mem_read  = d_mr;
      idex_d.mem_write = d_mw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign idex.id_valid     = idex_q.valid;
  assign idex.id_pc        = idex_q.pc;
  assign idex.id_op        = idex_q.op;
  assign idex.id_funct     = idex_q.funct;
  assign idex.id_rs        = idex_q.rs;
  assign idex.id_rt        = idex_q.rt;
  assign idex.id_rd        = idex_q.rd;
  assign idex.id_imm       = idex_q.imm;
  assign idex.id_rs_val    = idex_q.rs_val;
  assign idex.id_rt_val    = idex_q.rt_val;
  assign idex.id_reg_write = idex_q.reg_write;
  assign idex.id_mem_read  = idex_q.mem_read;
  assign idex.id_mem_write = idex_q.mem_write;

endmodule

// File: tb/tb_id_seg.sv
// tb/tb_id_seg.sv - self-checking bench for id_seg (vector table + scoreboard + corner sequences)
module tb_id_seg;
  localparam logic [31:0] BUB = 32'hFFFF_FFFF;

  logic        clk, rst;
  logic [31:0] ir_in, pc_in;
  logic        stall, cond;
  logic [31:0] cond_npc;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_read, ex_reg_write, mem_mem_read;
  logic [4:0]  ex_rd, mem_rd;

  id_seg_if idex();

  id_seg dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .pc_in(pc_in),
    .stall(stall), .cond(cond), .cond_npc(cond_npc),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .idex(idex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rw, mr, mw;
    logic        cnd;
    logic [31:0] npc;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rsv, rtv;
    logic        rw, mr, mw;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] model_rf [32];
  vec_t        vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] ir, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] imm, input logic rw, input logic mr, input logic mw);
    exp_t x;
    x.ir = ir; x.pc = pc; x.rd = rd; x.imm = imm;
    x.rsv = model_rf[ir[25:21]];
    x.rtv = model_rf[ir[20:16]];
    x.rw = rw; x.mr = mr; x.mw = mw;
    sbq.push_back(x);
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clk);
    wb_we = 1'b1; wb_rd = rd; wb_data = d;
    @(negedge clk);
    wb_we = 1'b0;
    if (rd != 5'd0) model_rf[rd] = d;
  endtask

  // Scoreboard consumer: every issued instruction must match the next expectation.
  always @(negedge clk) begin
    if (!rst && idex.id_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_issue actual_pc=%h required=none", idex.id_pc);
      end else begin
        e = sbq.pop_front();
        check($sformatf("pc@%h", e.pc), idex.id_pc, e.pc);
        check($sformatf("op@%h", e.pc), 32'(idex.id_op), 32'(e.ir[31:26]));
        check($sformatf("funct@%h", e.pc), 32'(idex.id_funct), 32'(e.ir[5:0]));
        check($sformatf("rs@%h", e.pc), 32'(idex.id_rs), 32'(e.ir[25:21]));
        check($sformatf("rt@%h", e.pc), 32'(idex.id_rt), 32'(e.ir[20:16]));
        check($sformatf("rd@%h", e.pc), 32'(idex.id_rd), 32'(e.rd));
        check($sformatf("imm@%h", e.pc), idex.id_imm, e.imm);
        check($sformatf("rs_val@%h", e.pc), idex.id_rs_val, e.rsv);
        check($sformatf("rt_val@%h", e.pc), idex.id_rt_val, e.rtv);
        check($sformatf("ctl@%h", e.pc),
              32'({idex.id_reg_write, idex.id_mem_read, idex.id_mem_write}),
              32'({e.rw, e.mr, e.mw}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h20010005, 32'h0000_0000, 5'd1,  32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{32'h00851820, 32'h0000_0004, 5'd3,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{32'h8C82FFFC, 32'h0000_0008, 5'd2,  32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{32'hAC880008, 32'h0000_000C, 5'd0,  32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{32'h30E98001, 32'h0000_0020, 5'd9,  32'h0000_8001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[5]  = '{32'h34EAF00F, 32'h0000_0024, 5'd10, 32'h0000_F00F, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[6]  = '{32'h3C0B1234, 32'h0000_0028, 5'd11, 32'h1234_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{32'h10850003, 32'h0000_0010, 5'd0,  32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020};
    vt[8]  = '{32'h14850003, 32'h0000_0010, 5'd0,  32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[9]  = '{32'h1487FFFE, 32'h0000_0040, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_003C};
    vt[10] = '{32'h1000FFEF, 32'h0000_0008, 5'd0,  32'hFFFF_FFEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFC8};
    vt[11] = '{32'h08000040, 32'hF000_0100, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0100};
    vt[12] = '{32'h0C000040, 32'h0000_0100, 5'd31, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100};
    vt[13] = '{32'hFC421234, 32'h0000_0050, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    rst = 1'b1; ir_in = BUB; pc_in = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
    mem_mem_read = 1'b0; mem_rd = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_cond", 32'(cond), 32'd0);
    check("rst_cond_npc", cond_npc, 32'd0);
    check("rst_id_valid", 32'(idex.id_valid), 32'd0);
    check("rst_id_pc", idex.id_pc, 32'd0);
    check("rst_id_imm", idex.id_imm, 32'd0);
    check("rst_id_ctl", 32'({idex.id_reg_write, idex.id_mem_read, idex.id_mem_write}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(idex.id_valid), 32'd0);

    // Register preload; the r0 write must have no effect.
    wb_write(5'd4, 32'd7);
    wb_write(5'd5, 32'd7);
    wb_write(5'd7, 32'd3);
    wb_write(5'd8, 32'h1234_5678);
    wb_write(5'd2, 32'h0000_0022);
    wb_write(5'd0, 32'h0000_DEAD);

    // Table: one instruction per three cycles, no hazards.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ir_in = vt[i].ir; pc_in = vt[i].pc;
      push_exp(vt[i].ir, vt[i].pc, vt[i].rd, vt[i].imm, vt[i].rw, vt[i].mr, vt[i].mw);
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      check($sformatf("vec%0d_cond", i), 32'(cond), 32'(vt[i].cnd));
      check($sformatf("vec%0d_cond_npc", i), cond_npc, vt[i].npc);
      ir_in = BUB;
      @(negedge clk);
      check($sformatf("vec%0d_squash", i), 32'(cond), 32'd0);
    end

    // Load with ex_rd=0 never stalls.
    @(negedge clk);
    ir_in = 32'h20010005; pc_in = 32'h0000_0180;
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    push_exp(32'h20010005, 32'h0000_0180, 5'd1, 32'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("exrd0_stall", 32'(stall), 32'd0);
    ir_in = BUB;

    // Load-use: add r3,r2,r2 behind lw r2.
    @(negedge clk);
    ir_in = 32'h00421820; pc_in = 32'h0000_0200;
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    push_exp(32'h00421820, 32'h0000_0200, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_cond", 32'(cond), 32'd0);
    ir_in = BUB;
    @(negedge clk);
    check("lu_bubble", 32'(idex.id_valid), 32'd0);
    check("lu_held", 32'(stall), 32'd1);
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_rd = 5'd2;
    #1;
    check("lu_release", 32'(stall), 32'd0);
    @(negedge clk);
    check("lu_issue", 32'(idex.id_valid), 32'd1);
    mem_mem_read = 1'b0; mem_rd = 5'd0;

    // Branch hazards: EX producer, then MEM load, then resolve.
    @(negedge clk);
    ir_in = 32'h10850003; pc_in = 32'h0000_0010;
    ex_reg_write = 1'b1; ex_rd = 5'd5;
    push_exp(32'h10850003, 32'h0000_0010, 5'd0, 32'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("brex_stall", 32'(stall), 32'd1);
    check("brex_cond", 32'(cond), 32'd0);
    check("brex_npc", cond_npc, 32'd0);
    ir_in = BUB;
    @(negedge clk);
    check("brex_bubble", 32'(idex.id_valid), 32'd0);
    ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_rd = 5'd4;
    #1;
    check("brmem_stall", 32'(stall), 32'd1);
    check("brmem_cond", 32'(cond), 32'd0);
    @(negedge clk);
    mem_mem_read = 1'b0; mem_rd = 5'd0;
    #1;
    check("br_stall_clear", 32'(stall), 32'd0);
    check("br_cond", 32'(cond), 32'd1);
    check("br_npc", cond_npc, 32'h0000_0020);
    @(negedge clk);
    check("br_squash", 32'(cond), 32'd0);
    check("br_ifid_bubble", 32'(stall), 32'd0);

    // Writeback to a register being read in ID.
    @(negedge clk);
    ir_in = 32'h20CC0001; pc_in = 32'h0000_0300;
    model_rf[6] = 32'h0000_00A5;
    push_exp(32'h20CC0001, 32'h0000_0300, 5'd12, 32'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    ir_in = BUB;
    wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000_00A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wb_stall", 32'(stall), 32'd0);
`else
    check("wb_stall", 32'(stall), 32'd1);
`endif
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    check("wb_stall_after", 32'(stall), 32'd0);
`ifdef REGFILE_BYPASS_EN
    check("wb_issue", 32'(idex.id_valid), 32'd1);
`else
    check("wb_issue", 32'(idex.id_valid), 32'd0);
`endif
    repeat (2) @(negedge clk);

    // Drain the scoreboard.
    for (int k = 0; k < 10 && sbq.size() != 0; k++) @(negedge clk);
    check("drain", 32'(sbq.size()), 32'd0);

    // Reset during a stall abandons the instruction.
    @(negedge clk);
    ir_in = 32'h00421820; pc_in = 32'h0000_0400;
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    @(negedge clk);
    check("rs_pre_stall", 32'(stall), 32'd1);
    ir_in = BUB;
    #2 rst = 1'b1;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    #1;
    check("rs_stall", 32'(stall), 32'd0);
    check("rs_cond", 32'(cond), 32'd0);
    check("rs_npc", cond_npc, 32'd0);
    check("rs_valid", 32'(idex.id_valid), 32'd0);
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    ir_in = 32'h20010005; pc_in = 32'h0000_0000;
    push_exp(32'h20010005, 32'h0000_0000, 5'd1, 32'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rs_first_bubble", 32'(idex.id_valid), 32'd0);
    ir_in = BUB;
    @(negedge clk);
    check("addi_valid", 32'(idex.id_valid), 32'd1);
    check("addi_rd", 32'(idex.id_rd), 32'd1);
    check("addi_imm", idex.id_imm, 32'd5);
    check("addi_rw", 32'(idex.id_reg_write), 32'd1);
    repeat (2) @(negedge clk);
    check("final_drain", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
